// File: rtl/approx_mul_err_sweep_if.sv
// Bus between the error-sweep engine and its surroundings: control handshake,
// operands out to the multiplier under test, product back, and the error metrics.
interface approx_mul_err_sweep_if #(
    parameter int XW = 8,
    parameter int YW = 8
);
    localparam int PW = XW + YW;

    logic                  start;
    logic                  busy;
    logic                  done;
    logic [XW-1:0]         x_out;
    logic [YW-1:0]         y_out;
    logic [PW-1:0]         z_in;
    logic [PW:0]           err_cnt;
    logic [2*PW-1:0]       sum_ed;
    logic [PW-1:0]         max_ed;
    logic signed [2*PW:0]  bias;

    modport master (
        input  start, z_in,
        output busy, done, x_out, y_out, err_cnt, sum_ed, max_ed, bias
    );

    modport slave (
        output start, z_in,
        input  busy, done, x_out, y_out, err_cnt, sum_ed, max_ed, bias
    );
endinterface

// File: rtl/approx_mul_err_sweep.sv
// Exhaustive error characterisation of an unsigned approximate multiplier:
// sweeps all operand pairs, compares each product against x*y, accumulates metrics.
module approx_mul_err_sweep #(
    parameter int XW      = 8,
    parameter int YW      = 8,
    parameter int MUL_LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    approx_mul_err_sweep_if.master bus
);
    localparam int PW = XW + YW;
    localparam logic [2:0] DRAIN_LAST = 3'(MUL_LAT + 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t               state;
    logic [PW-1:0]        cnt;
    logic [2:0]           dcnt;
    logic                 busy;
    logic                 done;
    logic                 go;
    logic                 vld_p0;

    logic [XW-1:0]        x_d;
    logic [YW-1:0]        y_d;
    logic                 vld_d;
    logic [PW-1:0]        exact_c;
    logic signed [PW:0]   diff_c;

    logic                 vld_p1;
    logic signed [PW:0]   diff_p1;
    logic [PW-1:0]        ed_p1;
    logic                 ne_p1;

    logic [PW:0]          err_cnt;
    logic [2*PW-1:0]      sum_ed;
    logic [PW-1:0]        max_ed;
    logic signed [2*PW:0] bias;

    // |d| always fits PW bits because both operands of the difference are PW-bit unsigned.
    function automatic logic [PW-1:0] abs_ed(input logic signed [PW:0] d);
        logic signed [PW:0] m;
        m = d[PW] ? -d : d;
        return m[PW-1:0];
    endfunction

    assign go          = bus.start && (state == IDLE || state == DONE);
    assign vld_p0      = (state == SWEEP);
    assign bus.x_out   = cnt[XW-1:0];
    assign bus.y_out   = cnt[PW-1:XW];
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.err_cnt = err_cnt;
    assign bus.sum_ed  = sum_ed;
    assign bus.max_ed  = max_ed;
    assign bus.bias    = bias;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        state <= SWEEP;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                SWEEP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == {PW{1'b1}}) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    // Hold until the last pair has passed the multiplier, stage E and stage A.
                    if (dcnt == DRAIN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand delay line: aligns each pair with the product the multiplier returns.
    generate
        if (MUL_LAT == 0) begin : g_nodly
            assign x_d   = bus.x_out;
            assign y_d   = bus.y_out;
            assign vld_d = vld_p0;
        end else begin : g_dly
            logic [XW-1:0]      x_pipe [MUL_LAT];
            logic [YW-1:0]      y_pipe [MUL_LAT];
            logic [MUL_LAT-1:0] v_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < MUL_LAT; i++) begin
                        x_pipe[i] <= '0;
                        y_pipe[i] <= '0;
                        v_pipe[i] <= 1'b0;
                    end
                end else begin
                    x_pipe[0] <= bus.x_out;
                    y_pipe[0] <= bus.y_out;
                    v_pipe[0] <= vld_p0;
                    for (int i = 1; i < MUL_LAT; i++) begin
                        x_pipe[i] <= x_pipe[i-1];
                        y_pipe[i] <= y_pipe[i-1];
                        v_pipe[i] <= v_pipe[i-1];
                    end
                end
            end

            assign x_d   = x_pipe[MUL_LAT-1];
            assign y_d   = y_pipe[MUL_LAT-1];
            assign vld_d = v_pipe[MUL_LAT-1];
        end
    endgenerate

    assign exact_c = PW'(x_d) * PW'(y_d);
    assign diff_c  = signed'({1'b0, bus.z_in}) - signed'({1'b0, exact_c});

    // Stage E: signed error, its magnitude and the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            diff_p1 <= '0;
            ed_p1   <= '0;
            ne_p1   <= 1'b0;
        end else begin
            vld_p1 <= vld_d;
            if (vld_d) begin
                diff_p1 <= diff_c;
                ed_p1   <= abs_ed(diff_c);
                ne_p1   <= (diff_c != '0);
            end
        end
    end

    // Stage A: accumulators; widths cover the worst case over all pairs, so no wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            sum_ed  <= '0;
            max_ed  <= '0;
            bias    <= '0;
        end else if (go) begin
            err_cnt <= '0;
            sum_ed  <= '0;
            max_ed  <= '0;
            bias    <= '0;
        end else if (vld_p1) begin
            err_cnt <= err_cnt + {{PW{1'b0}}, ne_p1};
            sum_ed  <= sum_ed + {{PW{1'b0}}, ed_p1};
            if (ed_p1 > max_ed) begin
                max_ed <= ed_p1;
            end
            bias    <= bias + {{PW{diff_p1[PW]}}, diff_p1};
        end
    end
endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// Scoreboard bench: two engines (multiplier latency 0 and 2) share one start and
// one behavioural multiplier model; expected metrics come from a plain-arithmetic sweep.
`timescale 1ns/1ps
module tb_approx_mul_err_sweep;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam int PW = XW + YW;
    localparam int N  = 1 << PW;

    typedef struct {
        longint err;
        longint sum;
        longint mx;
        longint bias;
    } res_t;

    typedef struct {
        logic          busy;
        logic          done;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        longint        err;
        longint        sum;
        longint        mx;
        longint        bias;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start;
    logic [PW-1:0] z0, z1a, z1;

    int mode;
    int err_tab [N];
    res_t q0 [$];
    res_t q1 [$];

    int checks = 0;
    int errors = 0;
    int idle_req = 0;
    int idle_seen = 0;
    bit fin_req = 1'b0;
    bit fin_ack = 1'b0;
    int bcnt [2];
    bit busy_prev [2];
    bit done_prev [2];

    always #5 clk = ~clk;

    approx_mul_err_sweep_if #(.XW(XW), .YW(YW)) bus0 ();
    approx_mul_err_sweep_if #(.XW(XW), .YW(YW)) bus1 ();

    assign bus0.start = start;
    assign bus1.start = start;
    assign bus0.z_in  = z0;
    assign bus1.z_in  = z1;

    approx_mul_err_sweep #(.XW(XW), .YW(YW), .MUL_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    approx_mul_err_sweep #(.XW(XW), .YW(YW), .MUL_LAT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    // Multiplier under test: 0 exact, 1 tied to zero, 2 off by +1, 3 table of errors,
    // 4 exact except a single fault at the largest operands.
    function automatic int model_z(input int x, input int y);
        int p;
        int z;
        p = x * y;
        case (mode)
            0: z = p;
            1: z = 0;
            2: z = p + 1;
            3: z = p + err_tab[y * (1 << XW) + x];
            default: z = (x == (1 << XW) - 1 && y == (1 << YW) - 1) ? 0 : p;
        endcase
        if (z < 0) z = 0;
        if (z > N - 1) z = N - 1;
        return z;
    endfunction

    always @(negedge clk) z0 = PW'(model_z(int'(bus0.x_out), int'(bus0.y_out)));

    always @(posedge clk) begin
        z1a <= PW'(model_z(int'(bus1.x_out), int'(bus1.y_out)));
        z1  <= z1a;
    end

    function automatic res_t ref_sweep();
        res_t r;
        longint d;
        r = '{0, 0, 0, 0};
        for (int y = 0; y < (1 << YW); y++) begin
            for (int x = 0; x < (1 << XW); x++) begin
                d = longint'(model_z(x, y)) - longint'(x * y);
                if (d != 0) r.err += 1;
                r.sum += (d < 0) ? -d : d;
                if (((d < 0) ? -d : d) > r.mx) r.mx = (d < 0) ? -d : d;
                r.bias += d;
            end
        end
        return r;
    endfunction

    task automatic check(input int i, input string nm, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0d expected %0d at %0t", i, nm, act, exp, $time);
        end
    endtask

    task automatic mon_dut(input int i, input snap_t s);
        res_t e;
        int idx;
        if (s.busy && !busy_prev[i]) begin
            check(i, "start_done", s.done, 0);
            check(i, "start_err_cnt", s.err, 0);
            check(i, "start_sum_ed", s.sum, 0);
            check(i, "start_max_ed", s.mx, 0);
            check(i, "start_bias", s.bias, 0);
        end
        if (s.busy) begin
            idx = bcnt[i];
            check(i, "op_x", s.x, (idx < N) ? idx % (1 << XW) : 0);
            check(i, "op_y", s.y, (idx < N) ? idx >> XW : 0);
            bcnt[i]++;
        end
        if (s.done && !done_prev[i]) begin
            check(i, "busy_len", bcnt[i], N + 2 * i + 2);
            check(i, "busy_at_done", s.busy, 0);
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                check(i, "unexpected_done", 1, 0);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                check(i, "err_cnt", s.err, e.err);
                check(i, "sum_ed", s.sum, e.sum);
                check(i, "max_ed", s.mx, e.mx);
                check(i, "bias", s.bias, e.bias);
            end
            bcnt[i] = 0;
        end
        busy_prev[i] = s.busy;
        done_prev[i] = s.done;
    endtask

    // Monitor: the only process that compares.
    always @(negedge clk) begin
        snap_t s [2];
        s[0] = '{bus0.busy, bus0.done, bus0.x_out, bus0.y_out, longint'(bus0.err_cnt),
                 longint'(bus0.sum_ed), longint'(bus0.max_ed), longint'(bus0.bias)};
        s[1] = '{bus1.busy, bus1.done, bus1.x_out, bus1.y_out, longint'(bus1.err_cnt),
                 longint'(bus1.sum_ed), longint'(bus1.max_ed), longint'(bus1.bias)};
        if (idle_req != idle_seen) begin
            idle_seen = idle_req;
            for (int i = 0; i < 2; i++) begin
                check(i, "idle_busy", s[i].busy, 0);
                check(i, "idle_done", s[i].done, 0);
                check(i, "idle_x", s[i].x, 0);
                check(i, "idle_y", s[i].y, 0);
                check(i, "idle_err_cnt", s[i].err, 0);
                check(i, "idle_sum_ed", s[i].sum, 0);
                check(i, "idle_max_ed", s[i].mx, 0);
                check(i, "idle_bias", s[i].bias, 0);
            end
        end
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 2; i++) begin
                bcnt[i] = 0;
                busy_prev[i] = 1'b0;
                done_prev[i] = 1'b0;
            end
        end else begin
            mon_dut(0, s[0]);
            mon_dut(1, s[1]);
            if (fin_req && !fin_ack) begin
                check(0, "pending_results", q0.size(), 0);
                check(1, "pending_results", q1.size(), 0);
                fin_ack = 1'b1;
            end
        end
    end

    task automatic do_start();
        res_t e;
        @(negedge clk);
        start = 1'b1;
        e = ref_sweep();
        q0.push_back(e);
        q1.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (bus0.done && bus1.done) break;
        end
    endtask

    task automatic run_sweep();
        do_start();
        wait_done();
    endtask

    task automatic rand_tab();
        for (int i = 0; i < N; i++) begin
            err_tab[i] = ($urandom_range(0, 3) == 0) ? (int'($urandom_range(0, 40)) - 20) : 0;
        end
        err_tab[$urandom_range(0, N - 1)] = -300;
        err_tab[$urandom_range(0, N - 1)] = 300;
    endtask

    initial begin
        start = 1'b0;
        mode  = 0;
        for (int i = 0; i < N; i++) err_tab[i] = 0;
        repeat (3) @(negedge clk);
        idle_req++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_req++;
        repeat (2) @(negedge clk);

        mode = 0; run_sweep();
        mode = 1; run_sweep();
        mode = 2; run_sweep();
        mode = 4; run_sweep();
        for (int k = 0; k < 3; k++) begin
            mode = 3;
            rand_tab();
            run_sweep();
        end

        // A second start mid-sweep must not disturb the sweep.
        mode = 3;
        rand_tab();
        do_start();
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Restart straight from DONE; the previous results were non-zero.
        mode = 0;
        run_sweep();

        // Asynchronous abort mid-sweep, then a clean exact sweep.
        mode = 3;
        rand_tab();
        do_start();
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle_req++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_req++;
        repeat (2) @(negedge clk);
        mode = 0;
        run_sweep();

        repeat (5) @(negedge clk);
        fin_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fin_ack) break;
        end
        if (!fin_ack) begin
            $display("FAIL final_handshake: got 0 expected 1");
            $fatal(1, "monitor did not complete");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
